// File: rtl/stopwatch_time_counter.sv
// BCD stopwatch time base (MM:SS.t), advanced by rising edges of the 10 Hz divider output.
// Optional lap-freeze feature enabled by defining LAP_HOLD_EN.
module stopwatch_time_counter #(
    parameter int unsigned SATURATE = 0
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       tick_in,
    input  logic       start_stop,
    input  logic       clear,
    input  logic       lap,
    output logic [3:0] tenths,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [3:0] min_tens,
    output logic       running,
    output logic       overflow
);
    localparam logic P_SAT = (SATURATE != 0);

    logic       r_tick_q;
    logic       r_running;
    logic       r_overflow;
    logic       r_lap_frozen;
    logic [3:0] r_t, r_so, r_st, r_mo, r_mt;
    logic [3:0] r_out_t, r_out_so, r_out_st, r_out_mo, r_out_mt;

    logic       w_rise, w_adv, w_hold;
    logic       w_c_t, w_c_so, w_c_st, w_c_mo, w_at_max;
    logic [3:0] w_nx_t, w_nx_so, w_nx_st, w_nx_mo, w_nx_mt;

    function automatic logic [3:0] f_inc(input logic [3:0] d, input logic [3:0] lim);
        return (d == lim) ? '0 : d + 4'd1;
    endfunction

    assign w_rise = tick_in & ~r_tick_q;
    assign w_adv  = w_rise & r_running;

    // Ripple carry across digits, resolved combinationally so one tick carries all the way.
    assign w_c_t    = (r_t == 4'd9);
    assign w_c_so   = w_c_t  & (r_so == 4'd9);
    assign w_c_st   = w_c_so & (r_st == 4'd5);
    assign w_c_mo   = w_c_st & (r_mo == 4'd9);
    assign w_at_max = w_c_mo & (r_mt == 4'd5);

    assign w_nx_t  = f_inc(r_t, 4'd9);
    assign w_nx_so = w_c_t  ? f_inc(r_so, 4'd9) : r_so;
    assign w_nx_st = w_c_so ? f_inc(r_st, 4'd5) : r_st;
    assign w_nx_mo = w_c_st ? f_inc(r_mo, 4'd9) : r_mo;
    assign w_nx_mt = w_c_mo ? f_inc(r_mt, 4'd5) : r_mt;

    // Display registers freeze only while a lap is held and no lap/clear pulse is arriving.
    assign w_hold = r_lap_frozen & ~lap & ~clear;

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_tick_q     <= 1'b0;
            r_running    <= 1'b0;
            r_overflow   <= 1'b0;
            r_lap_frozen <= 1'b0;
            {r_mt, r_mo, r_st, r_so, r_t}                     <= '0;
            {r_out_mt, r_out_mo, r_out_st, r_out_so, r_out_t} <= '0;
        end else begin
            r_tick_q <= tick_in;
            if (!w_hold)
                {r_out_mt, r_out_mo, r_out_st, r_out_so, r_out_t} <= {r_mt, r_mo, r_st, r_so, r_t};
            if (clear) begin
                {r_mt, r_mo, r_st, r_so, r_t} <= '0;
                r_running    <= 1'b0;
                r_overflow   <= 1'b0;
                r_lap_frozen <= 1'b0;
            end else begin
                if (start_stop)
                    r_running <= ~r_running;
                if (!P_SAT)
                    r_overflow <= 1'b0;
                if (w_adv) begin
                    if (w_at_max && P_SAT) begin
                        r_running  <= 1'b0;
                        r_overflow <= 1'b1;
                    end else begin
                        {r_mt, r_mo, r_st, r_so, r_t} <= {w_nx_mt, w_nx_mo, w_nx_st, w_nx_so, w_nx_t};
                        if (w_at_max)
                            r_overflow <= 1'b1;
                    end
                end
`ifdef LAP_HOLD_EN
                if (lap)
                    r_lap_frozen <= ~r_lap_frozen;
`else
                r_lap_frozen <= 1'b0;
`endif
            end
        end
    end

    assign tenths   = r_out_t;
    assign sec_ones = r_out_so;
    assign sec_tens = r_out_st;
    assign min_ones = r_out_mo;
    assign min_tens = r_out_mt;
    assign running  = r_running;
    assign overflow = r_overflow;
endmodule
